// File: rtl/seg_scan_driver.sv
// rtl/seg_scan_driver.sv - multiplexed 7-segment scan driver with blink, blanking and leading-zero suppression
//
// Ports:
//   clk        system clock, all logic on rising edge
//   rst        synchronous active-high reset
//   load       capture strobe for all display inputs
//   data_in    hex nibbles, digit i = data_in[4i+3:4i]
//   dp_in      decimal-point request per digit (1 = lit)
//   blank_mask 1 = digit forced dark
//   blink_mask 1 = digit blinks
//   lz_en      leading-zero suppression enable
//   seg_out    segments a..g (index 0 = a), active-low
//   dp_out     decimal point, active-low
//   an_out     digit select, active-low one-hot
//   frame_done one-cycle pulse when the scan index wraps to digit 0
module seg_scan_driver #(
  parameter int DIGITS    = 6,
  parameter int SCAN_DIV  = 1000,
  parameter int BLINK_DIV = 250000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   data_in,
  input  logic [DIGITS-1:0]     dp_in,
  input  logic [DIGITS-1:0]     blank_mask,
  input  logic [DIGITS-1:0]     blink_mask,
  input  logic                  lz_en,
  output logic [0:6]            seg_out,
  output logic                  dp_out,
  output logic [DIGITS-1:0]     an_out,
  output logic                  frame_done
);

  localparam int SW = $clog2(SCAN_DIV);
  localparam int BW = $clog2(BLINK_DIV);
  localparam int IW = $clog2(DIGITS);

  logic [SW-1:0]       prescaler;
  logic [BW-1:0]       blink_cnt;
  logic                blink_phase;
  logic [IW-1:0]       idx;

  logic [4*DIGITS-1:0] data_q;
  logic [DIGITS-1:0]   dp_q;
  logic [DIGITS-1:0]   blank_q;
  logic [DIGITS-1:0]   blink_q;
  logic                lz_q;

  logic                scan_tc;
  logic                blink_tc;
  logic                idx_last;
  logic [3:0]          cur_nibble;
  logic                upper_nonzero;
  logic                dark;
  logic [0:6]          seg_next;
  logic                dp_next;
  logic [DIGITS-1:0]   an_next;

  function automatic logic [0:6] decode(input logic [3:0] nib);
    case (nib)
      4'h0: decode = 7'b0000001;
      4'h1: decode = 7'b1001111;
      4'h2: decode = 7'b0010010;
      4'h3: decode = 7'b0000110;
      4'h4: decode = 7'b1001100;
      4'h5: decode = 7'b0100100;
      4'h6: decode = 7'b0100000;
      4'h7: decode = 7'b0001101;
      4'h8: decode = 7'b0000000;
      4'h9: decode = 7'b0000100;
      4'hA: decode = 7'b0001000;
      4'hB: decode = 7'b1100000;
      4'hC: decode = 7'b0110001;
      4'hD: decode = 7'b1000010;
      4'hE: decode = 7'b0110000;
      default: decode = 7'b0111000;
    endcase
  endfunction

  assign scan_tc  = (prescaler == SW'(SCAN_DIV - 1));
  assign blink_tc = (blink_cnt == BW'(BLINK_DIV - 1));
  assign idx_last = (idx == IW'(DIGITS - 1));

  always_comb begin
    cur_nibble    = data_q[4*int'(idx) +: 4];
    // A digit is a leading zero when it and every more significant digit is zero.
    upper_nonzero = 1'b0;
    for (int k = 0; k < DIGITS; k++) begin
      if (k >= int'(idx) && data_q[4*k +: 4] != 4'd0) upper_nonzero = 1'b1;
    end
    dark = blank_q[idx]
         | (blink_q[idx] & blink_phase)
         | (lz_q & (idx != '0) & ~upper_nonzero);
    seg_next = dark ? 7'b1111111 : decode(cur_nibble);
    dp_next  = dark ? 1'b1 : ~dp_q[idx];
    an_next  = '1;
    an_next[idx] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      prescaler   <= '0;
      blink_cnt   <= '0;
      blink_phase <= 1'b0;
      idx         <= '0;
      data_q      <= '0;
      dp_q        <= '0;
      blank_q     <= '0;
      blink_q     <= '0;
      lz_q        <= 1'b0;
      seg_out     <= 7'b1111111;
      dp_out      <= 1'b1;
      an_out      <= '1;
      frame_done  <= 1'b0;
    end else begin
      prescaler <= scan_tc ? '0 : prescaler + SW'(1);
      if (scan_tc) idx <= idx_last ? '0 : idx + IW'(1);
      frame_done <= scan_tc & idx_last;

      blink_cnt <= blink_tc ? '0 : blink_cnt + BW'(1);
      if (blink_tc) blink_phase <= ~blink_phase;

      if (load) begin
        data_q  <= data_in;
        dp_q    <= dp_in;
        blank_q <= blank_mask;
        blink_q <= blink_mask;
        lz_q    <= lz_en;
      end

      seg_out <= seg_next;
      dp_out  <= dp_next;
      an_out  <= an_next;
    end
  end

endmodule

// File: tb/tb_seg_scan_driver.sv
// tb/tb_seg_scan_driver.sv - randomized self-checking bench for seg_scan_driver
module tb_seg_scan_driver;

  localparam int D     = 4;
  localparam int SCAN  = 4;
  localparam int BLINK = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          load;
  logic [15:0]   data_in;
  logic [3:0]    dp_in;
  logic [3:0]    blank_mask;
  logic [3:0]    blink_mask;
  logic          lz_en;
  logic [0:6]    seg_out;
  logic          dp_out;
  logic [3:0]    an_out;
  logic          frame_done;

  int checks = 0;
  int errors = 0;

  // reference state: shadow contents and edges elapsed since reset
  logic [15:0] m_data;
  logic [3:0]  m_dp, m_blank, m_blink;
  logic        m_lz;
  int          e;

  logic [6:0]  font [16];

  seg_scan_driver #(.DIGITS(D), .SCAN_DIV(SCAN), .BLINK_DIV(BLINK)) dut (
    .clk(clk), .rst(rst), .load(load), .data_in(data_in), .dp_in(dp_in),
    .blank_mask(blank_mask), .blink_mask(blink_mask), .lz_en(lz_en),
    .seg_out(seg_out), .dp_out(dp_out), .an_out(an_out), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    if (obs !== expv) begin
      errors++;
      $display("FAIL %s: got %h expected %h (edge %0d)", tag, obs, expv, e);
    end
  endtask

  task automatic tick();
    logic [6:0] es;
    logic       ed, ef, dk;
    logic [3:0] ea;
    int ix, ph;
    @(posedge clk);
    if (rst) begin
      es = 7'h7f; ed = 1'b1; ea = 4'hf; ef = 1'b0;
      m_data = '0; m_dp = '0; m_blank = '0; m_blink = '0; m_lz = 1'b0;
      e = 0;
    end else begin
      ix = (e / SCAN) % D;
      ph = (e / BLINK) % 2;
      dk = m_blank[ix] || (m_blink[ix] && ph == 1) ||
           (m_lz && ix > 0 && (m_data >> (4*ix)) == 16'd0);
      es = dk ? 7'h7f : font[(m_data >> (4*ix)) & 16'hf];
      ed = dk ? 1'b1 : ~m_dp[ix];
      ea = ~(4'b0001 << ix);
      ef = (e % (SCAN*D)) == (SCAN*D - 1);
      if (load) begin
        m_data = data_in; m_dp = dp_in; m_blank = blank_mask;
        m_blink = blink_mask; m_lz = lz_en;
      end
      e++;
    end
    @(negedge clk);
    check_eq("seg_out", 32'(seg_out), 32'(es));
    check_eq("dp_out", 32'(dp_out), 32'(ed));
    check_eq("an_out", 32'(an_out), 32'(ea));
    check_eq("frame_done", 32'(frame_done), 32'(ef));
  endtask

  task automatic do_load(input logic [15:0] d, input logic [3:0] dp, input logic [3:0] bl,
                         input logic [3:0] bk, input logic lz);
    data_in = d; dp_in = dp; blank_mask = bl; blink_mask = bk; lz_en = lz;
    load = 1'b1;
    tick();
    load = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    font[0]  = 7'b0000001; font[1]  = 7'b1001111; font[2]  = 7'b0010010; font[3]  = 7'b0000110;
    font[4]  = 7'b1001100; font[5]  = 7'b0100100; font[6]  = 7'b0100000; font[7]  = 7'b0001101;
    font[8]  = 7'b0000000; font[9]  = 7'b0000100; font[10] = 7'b0001000; font[11] = 7'b1100000;
    font[12] = 7'b0110001; font[13] = 7'b1000010; font[14] = 7'b0110000; font[15] = 7'b0111000;

    e = 0;
    rst = 1'b1; load = 1'b0; data_in = '0; dp_in = '0;
    blank_mask = '0; blink_mask = '0; lz_en = 1'b0;
    m_data = '0; m_dp = '0; m_blank = '0; m_blink = '0; m_lz = 1'b0;
    idle(2);
    rst = 1'b0;

    // first edge after reset: digit 0 selected showing zero
    tick();
    check_eq("first_seg", 32'(seg_out), 32'(7'b0000001));
    check_eq("first_an", 32'(an_out), 32'(4'b1110));
    idle(40);

    do_load(16'h1A2F, 4'b0010, 4'b0000, 4'b0000, 1'b0);
    idle(20);
    do_load(16'h0050, 4'b0000, 4'b0000, 4'b0000, 1'b1);
    idle(20);
    do_load(16'h0000, 4'b0000, 4'b0000, 4'b0000, 1'b1);
    idle(20);
    do_load(16'h8888, 4'b0000, 4'b0000, 4'b0001, 1'b0);
    idle(140);
    do_load(16'h1234, 4'b1111, 4'b0100, 4'b0100, 1'b0);
    idle(70);

    // reset mid-scan at index 2 together with a load
    while (((e / SCAN) % D) != 2) tick();
    rst = 1'b1;
    data_in = 16'hFFFF; dp_in = 4'hF; lz_en = 1'b1; load = 1'b1;
    tick();
    rst = 1'b0; load = 1'b0;
    idle(20);

    for (int i = 0; i < 3000; i++) begin
      rst = ($urandom_range(0, 299) == 0);
      if ($urandom_range(0, 15) == 0) begin
        data_in    = 16'($urandom) >> (4 * $urandom_range(0, 4));
        dp_in      = 4'($urandom);
        blank_mask = 4'($urandom) & 4'($urandom) & 4'($urandom);
        blink_mask = 4'($urandom) & 4'($urandom);
        lz_en      = 1'($urandom);
        load = 1'b1;
      end else begin
        load = 1'b0;
      end
      tick();
    end
    rst = 1'b0; load = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/seg_scan_driver.md
SEG_SCAN_DRIVER -- requirements
Module: seg_scan_driver

Interface
REQ-001 The block SHALL have parameter DIGITS, default 6, giving the number of multiplexed 7-segment digits (range 2..8).
REQ-002 The block SHALL have parameter SCAN_DIV, default 1000, giving clock cycles per digit slot (minimum 2).
REQ-003 The block SHALL have parameter BLINK_DIV, default 250000, giving clock cycles per blink half-period (minimum 2).
REQ-004 The block SHALL use a single clock and a synchronous, active-high reset.
REQ-005 The ports SHALL be, one per line:
 clk  in  1  system clock, all logic on rising edge
 rst  in  1  synchronous active-high reset
 load  in  1  capture strobe for all display inputs
 data_in  in  4*DIGITS  hex nibbles; digit i = data_in[4i+3:4i], digit 0 least significant
 dp_in  in  DIGITS  decimal-point request per digit, 1 = lit
 blank_mask  in  DIGITS  1 = digit forced dark
 blink_mask  in  DIGITS  1 = digit blinks
 lz_en  in  1  leading-zero suppression enable
 seg_out  out  [0:6]  segments a..g, index 0 = a, active-low
 dp_out  out  1  decimal point, active-low
 an_out  out  DIGITS  digit select, active-low, one-hot-low
 frame_done  out  1  one-cycle pulse at end of each full scan

Function
REQ-006 The block SHALL hold shadow registers for data_in, dp_in, blank_mask, blink_mask and lz_en, all captured on any rising edge with load=1 and otherwise held.
REQ-007 A prescaler SHALL count 0..SCAN_DIV-1 and wrap; on its terminal count the digit index SHALL advance by 1 modulo DIGITS.
REQ-008 frame_done SHALL be 1 for exactly the cycle in which the index wraps from DIGITS-1 to 0, else 0.
REQ-009 A blink counter SHALL count 0..BLINK_DIV-1 independently of the scan, toggling blink_phase at each terminal count.
REQ-010 seg_out, dp_out and an_out SHALL be registered, reflecting the current index and shadow registers with 1-cycle latency.
REQ-011 an_out bit k SHALL be 0 if and only if k equals the current index; all other bits 1.
REQ-012 For a visible digit, seg_out SHALL encode the nibble (a..g, active-low): 0=0000001, 1=1001111, 2=0010010, 3=0000110, 4=1001100, 5=0100100, 6=0100000, 7=0001101, 8=0000000, 9=0000100, A=0001000, b=1100000, C=0110001, d=1000010, E=0110000, F=0111000.
REQ-013 dp_out SHALL be the inverse of the shadow dp bit for the current digit when visible.
REQ-014 A digit SHALL be dark (seg_out=1111111, dp_out=1, an_out still selects it) when its blank_mask bit is 1, or its blink_mask bit is 1 and blink_phase=1, or it is leading-zero suppressed.
REQ-015 With lz_en=1, digit k (k>=1) SHALL be suppressed if and only if the nibbles of digits k..DIGITS-1 are all zero; digit 0 SHALL never be suppressed.
REQ-016 Leading-zero suppression SHALL darken the digit's dp only as part of REQ-014.
REQ-017 Priority SHALL be blank_mask, then blink, then leading-zero, then normal decode; any dark condition wins.
REQ-018 A load in the same cycle as an index advance SHALL capture normally; the newly selected digit shows the new data from the second edge after load.
REQ-019 load SHALL NOT reset the prescaler, index or blink counter.

Reset
REQ-020 On rst=1 at a rising edge: prescaler=0, index=0, blink counter=0, blink_phase=0, all shadow registers 0, seg_out=1111111, dp_out=1, an_out all 1, frame_done=0.
REQ-021 rst SHALL take priority over load and over any counter event in the same cycle, including mid-scan.
REQ-022 On the first edge after rst deasserts, an_out SHALL select digit 0 with shadow contents (zeros, so seg_out=0000001).

Verification (DIGITS=4, SCAN_DIV=4, BLINK_DIV=32)
REQ-023 Reset then idle -> an_out cycles 1110,1101,1011,0111 every 4 clocks; frame_done pulses once per 16 clocks at the 3->0 wrap.
REQ-024 load data_in=16'h1A2F, dp_in=0010 -> digit0 seg 0111000, digit1 seg 0010010 dp_out=0, digit2 seg 0001000, digit3 seg 1001111.
REQ-025 load data_in=16'h0050, lz_en=1 -> digits 3 and 2 dark, digit1 0100100, digit0 0000001; data_in=16'h0000 -> only digit0 lit showing 0.
REQ-026 load blink_mask=0001, data 16'h8888 -> digit0 lit 32 clocks, dark 32 clocks, repeating; digits 1..3 always 0000000.
REQ-027 blank_mask=0100 together with blink_mask=0100 -> digit2 dark in both blink phases.
REQ-028 rst asserted mid-scan at index 2 with load=1 -> next cycle outputs all 1, shadow zero, index 0; load ignored.
